// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared constants and FSM state encoding for cache_controller
// Revision  : 1.0
// ============================================================================
package cache_pkg;

  localparam int c_ADDR_W    = 16;
  localparam int c_DATA_W    = 16;
  localparam int c_INDEX_W   = 4;
  localparam int c_TAG_W     = c_ADDR_W - c_INDEX_W;
  localparam int c_NUM_LINES = 1 << c_INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_controller_if.sv
`default_nettype none
// ============================================================================
// cache_controller_if : processor-side and main-memory-side cache signals
// Revision            : 1.0
// ============================================================================
interface cache_controller_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rd;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic              hit;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // master = processor + main memory, slave = the cache controller
  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_we, mem_rdata, mem_ready,
    input  cpu_rdata, hit, busy, mem_addr, mem_wdata, mem_rd, mem_we
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_we, mem_rdata, mem_ready,
    output cpu_rdata, hit, busy, mem_addr, mem_wdata, mem_rd, mem_we
  );

endinterface
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// cache_line_store : valid/tag/data arrays, one async read port, one sync write
// Revision         : 1.0
// ============================================================================
module cache_line_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = c_INDEX_W,
  parameter int TAG_W   = c_TAG_W,
  parameter int DATA_W  = c_DATA_W
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [INDEX_W-1:0] i_rd_index,
  output logic                    o_rd_valid,
  output logic      [TAG_W-1:0]   o_rd_tag,
  output logic      [DATA_W-1:0]  o_rd_data,
  input  wire logic               i_wr_en,
  input  wire logic [INDEX_W-1:0] i_wr_index,
  input  wire logic [TAG_W-1:0]   i_wr_tag,
  input  wire logic [DATA_W-1:0]  i_wr_data
);

  localparam int NUM_LINES = 1 << INDEX_W;

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [DATA_W-1:0]    r_data [NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data keep their contents across reset; only valid bits matter.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// cache_controller : direct-mapped write-through no-write-allocate word cache
// Revision         : 1.0
// ============================================================================
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W  = c_ADDR_W,
  parameter int DATA_W  = c_DATA_W,
  parameter int INDEX_W = c_INDEX_W
) (
  input wire logic          clk_100,
  input wire logic          rst,
  cache_controller_if.slave bus
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_line_valid;
  logic [TAG_W-1:0]    w_line_tag;
  logic [DATA_W-1:0]   w_line_data;
  logic [INDEX_W-1:0]  w_cpu_index;
  logic [TAG_W-1:0]    w_cpu_tag;
  logic                w_line_match;
  logic                w_fill;
  logic                w_wr_hit;
  logic                w_store_we;
  logic [INDEX_W-1:0]  w_store_index;
  logic [TAG_W-1:0]    w_store_tag;
  logic [DATA_W-1:0]   w_store_data;
  logic                w_hit;
  logic [DATA_W-1:0]   w_rdata;

  assign w_cpu_index  = bus.cpu_addr[INDEX_W-1:0];
  assign w_cpu_tag    = bus.cpu_addr[ADDR_W-1:INDEX_W];
  assign w_line_match = w_line_valid && (w_line_tag == w_cpu_tag);

  // A fill comes from the latched miss address; a write hit from the live CPU bus.
  assign w_fill        = (r_state == RD_MISS) && bus.mem_ready;
  assign w_wr_hit      = (r_state == IDLE) && bus.cpu_we && w_line_match;
  assign w_store_we    = (w_fill || w_wr_hit) && !rst;
  assign w_store_index = w_fill ? r_mem_addr[INDEX_W-1:0]      : w_cpu_index;
  assign w_store_tag   = w_fill ? r_mem_addr[ADDR_W-1:INDEX_W] : w_cpu_tag;
  assign w_store_data  = w_fill ? bus.mem_rdata                : bus.cpu_wdata;

  cache_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_store (
    .clk        (clk_100),
    .rst        (rst),
    .i_rd_index (w_cpu_index),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_wr_en    (w_store_we),
    .i_wr_index (w_store_index),
    .i_wr_tag   (w_store_tag),
    .i_wr_data  (w_store_data)
  );

  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      if ((r_state == IDLE) && (bus.cpu_we || bus.cpu_rd)) begin
        r_mem_addr <= bus.cpu_addr;
      end
      if ((r_state == IDLE) && bus.cpu_we) begin
        r_mem_wdata <= bus.cpu_wdata;
      end
      if (w_fill) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_hit        = 1'b0;
    w_rdata      = '0;
    case (r_state)
      IDLE: begin
        if (bus.cpu_we) begin
          w_next_state = WR_THRU;
        end else if (bus.cpu_rd && w_line_match) begin
          w_hit   = 1'b1;
          w_rdata = w_line_data;
        end else if (bus.cpu_rd) begin
          w_next_state = RD_MISS;
        end
      end
      RD_MISS: begin
        if (bus.mem_ready) w_next_state = DONE;
      end
      WR_THRU: begin
        if (bus.mem_ready) w_next_state = DONE;
      end
      DONE: begin
        w_hit        = 1'b1;
        w_rdata      = r_rdata;
        w_next_state = IDLE;
      end
    endcase
  end

  assign bus.hit       = w_hit;
  assign bus.cpu_rdata = w_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.mem_rd    = (r_state == RD_MISS);
  assign bus.mem_we    = (r_state == WR_THRU);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// tb_cache_controller : directed vector bench for cache_controller
// Revision            : 1.0
// ============================================================================
module tb_cache_controller;
  import cache_pkg::*;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    int          delay;
    logic        exp_imm;
    logic [15:0] exp_rdata;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t pre  [17];
  vec_t post [3];
  vec_t last;

  cache_controller_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_controller dut (
    .clk_100 (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Presents one request in IDLE and, on a miss/write, plays the memory side.
  task automatic access(input vec_t v, input string tag);
    logic held;
    @(negedge clk);
    bus.cpu_we    = v.we;
    bus.cpu_rd    = !v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    #1;
    chk({tag, " imm_hit"}, bus.hit, v.exp_imm);
    chk({tag, " idle_busy"}, bus.busy, 1'b0);
    if (v.exp_imm) begin
      chk({tag, " imm_rdata"}, bus.cpu_rdata, v.exp_rdata);
      @(negedge clk);
      bus.cpu_rd = 1'b0;
      #1;
      chk({tag, " no_mem_req"}, {bus.mem_rd, bus.mem_we}, 2'b00);
      chk({tag, " hit_busy"}, bus.busy, 1'b0);
    end else begin
      @(negedge clk);
      bus.cpu_we    = 1'b0;
      bus.cpu_rd    = 1'b0;
      bus.cpu_addr  = ~v.addr;
      bus.cpu_wdata = ~v.wdata;
      #1;
      chk({tag, " mem_rd"}, bus.mem_rd, !v.we);
      chk({tag, " mem_we"}, bus.mem_we, v.we);
      chk({tag, " mem_addr"}, bus.mem_addr, v.addr);
      if (v.we) chk({tag, " mem_wdata"}, bus.mem_wdata, v.wdata);
      chk({tag, " req_busy_nohit"}, {bus.busy, bus.hit}, 2'b10);
      held = 1'b1;
      for (int k = 0; k < v.delay; k++) begin
        @(negedge clk);
        #1;
        if (bus.mem_rd !== !v.we || bus.mem_we !== v.we || bus.hit !== 1'b0) held = 1'b0;
      end
      chk({tag, " req_held"}, held, 1'b1);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = v.mdata;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      #1;
      chk({tag, " done_hit"}, bus.hit, 1'b1);
      chk({tag, " done_busy"}, bus.busy, 1'b1);
      chk({tag, " done_req_off"}, {bus.mem_rd, bus.mem_we}, 2'b00);
      if (!v.we) chk({tag, " done_rdata"}, bus.cpu_rdata, v.exp_rdata);
      @(negedge clk);
      #1;
      chk({tag, " back_idle"}, {bus.busy, bus.hit}, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          we    addr      wdata     mdata     dly imm   exp_rdata
    pre[0]  = '{1'b0, 16'h0013, 16'h0000, 16'hBEEF, 3, 1'b0, 16'hBEEF};
    pre[1]  = '{1'b0, 16'h0013, 16'h0000, 16'h0000, 0, 1'b1, 16'hBEEF};
    pre[2]  = '{1'b1, 16'h0013, 16'h1234, 16'h0000, 2, 1'b0, 16'h0000};
    pre[3]  = '{1'b0, 16'h0013, 16'h0000, 16'h0000, 0, 1'b1, 16'h1234};
    pre[4]  = '{1'b0, 16'h0023, 16'h0000, 16'h5555, 1, 1'b0, 16'h5555};
    pre[5]  = '{1'b0, 16'h0023, 16'h0000, 16'h0000, 0, 1'b1, 16'h5555};
    pre[6]  = '{1'b0, 16'h0013, 16'h0000, 16'h1234, 0, 1'b0, 16'h1234};
    pre[7]  = '{1'b1, 16'h0045, 16'hA5A5, 16'h0000, 1, 1'b0, 16'h0000};
    pre[8]  = '{1'b0, 16'h0045, 16'h0000, 16'h7777, 2, 1'b0, 16'h7777};
    pre[9]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hCAFE, 1, 1'b0, 16'hCAFE};
    pre[10] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 1'b1, 16'hCAFE};
    pre[11] = '{1'b0, 16'h000F, 16'h0000, 16'h0F0F, 1, 1'b0, 16'h0F0F};
    pre[12] = '{1'b0, 16'hFFFF, 16'h0000, 16'hCAFE, 4, 1'b0, 16'hCAFE};
    pre[13] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1, 1'b0, 16'h0000};
    pre[14] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 1'b1, 16'h0001};
    pre[15] = '{1'b1, 16'h0023, 16'hBBBB, 16'h0000, 1, 1'b0, 16'h0000};
    pre[16] = '{1'b0, 16'h0013, 16'h0000, 16'h0000, 0, 1'b1, 16'h1234};
    last    = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 1'b1, 16'h0001};
    post[0] = '{1'b0, 16'h0067, 16'h0000, 16'h1111, 2, 1'b0, 16'h1111};
    post[1] = '{1'b0, 16'h0013, 16'h0000, 16'h4321, 1, 1'b0, 16'h4321};
    post[2] = '{1'b0, 16'h0067, 16'h0000, 16'h0000, 0, 1'b1, 16'h1111};

    rst           = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {bus.busy, bus.hit, bus.mem_rd, bus.mem_we}, 4'b0000);
    chk("reset_rdata", bus.cpu_rdata, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) access(pre[i], $sformatf("pre%0d", i));

    // A stray mem_ready in IDLE must not start or complete anything.
    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hBAD0;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("idle_ready_ignored", {bus.busy, bus.hit, bus.mem_rd, bus.mem_we}, 4'b0000);
    access(last, "idle_ready_hit");

    // Reset two cycles into a read miss on line 7.
    @(negedge clk);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 16'h0067;
    #1;
    chk("rstmiss_first_hit", bus.hit, 1'b0);
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    #1;
    chk("rstmiss_rd_c1", bus.mem_rd, 1'b1);
    @(negedge clk);
    #1;
    chk("rstmiss_rd_c2", bus.mem_rd, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmiss_rd_off", {bus.mem_rd, bus.busy}, 2'b00);
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h9999;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("rstmiss_late_ready", {bus.busy, bus.hit, bus.mem_rd, bus.mem_we}, 4'b0000);

    for (int i = 0; i < 3; i++) access(post[i], $sformatf("post%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
